pc_fetch_unit: RTL

- Program-counter register and instruction-fetch front end of the RISC-V core.
- Consumes the next-PC selected by the PC-source mux and publishes pc_plus4 back to that mux as its sequential input.
- Issues single-outstanding requests to instruction memory and presents a fetched instruction (IF/ID slot) to decode.
- Supports decode stall, via a one-entry skid buffer, and control-flow redirect/flush.

---
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch front end: single outstanding imem
// request, IF/ID slot with a one-entry skid buffer, redirect/flush.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             next_pc,
  input  logic                    redirect,
  input  logic                    stall,
  output logic [31:0]             pc_out,
  output logic [31:0]             pc_plus4,
  pc_fetch_unit_if.master         imem,
  output logic                    if_valid,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  // Skid buffer occupancy is implied by state_q == S_HOLD.
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] pc_inc;

  assign pc_inc         = pc_q + 32'd4;
  assign pc_out         = pc_q;
  assign pc_plus4       = pc_inc;
  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

  // Next-state logic: redirect overrides stall and data capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    // Decode consumes the slot; may be overwritten by new data below.
    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    if (redirect) begin
      pc_d       = next_pc;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      unique case (state_q)
        S_REQ: begin
          if (imem.imem_gnt) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem.imem_gnt) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (!if_valid_q || !stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_instr_d = imem.imem_rdata;
              pc_d       = pc_inc;
              state_d    = S_REQ;
            end else begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem.imem_rdata;
              pc_d         = pc_inc;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_instr_d = skid_instr_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule
